fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly downstream of the program counter block. Each cycle it presents the current PC to the instruction cache, tells the PC block when it may take its next value, and delivers fetched instructions into the IF/ID latch. A one-entry skid buffer decouples cache hits from decode stalls, and a squash state absorbs cache misses that are still outstanding when a branch or jump flush arrives.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/fetch_skid_buf.sv | 40 ++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states, IF/ID bundle and halt decode.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'h3F;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t npc;
    logic  valid;
  } ifid_t;

  // True when an opcode field matches the opcode that stops fetch
  function automatic logic isHalt(input logic [5:0] opcode, input logic [5:0] haltOp);
    return opcode == haltOp;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry skid buffer holding one fetched word while decode is stalled.
module fetch_skid_buf
  import cpu_types_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  logic  clear_i,
  input  word_t instr_i,
  input  word_t pc_i,
  input  word_t npc_i,
  output word_t instr_o,
  output word_t pc_o,
  output word_t npc_o
);

  word_t instr_q, pc_q, npc_q;

  // Capture a word on load; wipe it when drained or discarded by a flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q <= '0;
      pc_q    <= '0;
      npc_q   <= '0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      npc_q   <= npc_i;
    end else if (clear_i) begin
      instr_q <= '0;
      pc_q    <= '0;
      npc_q   <= '0;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign npc_o   = npc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the I-cache, paces the PC block and fills IF/ID.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
)
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc,
  output logic        pc_incr,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid
);

  fetch_state_t state_q, state_d;
  ifid_t        ifid_q, ifid_d;
  word_t        reqAddr_q, reqAddr_d;
  word_t        pcPlus4;
  logic         skidLoad, skidClear;
  word_t        skidInstr, skidPc, skidNpc;

  assign pcPlus4 = pc + 32'd4;

  fetch_skid_buf u_skid (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (skidLoad),
    .clear_i (skidClear),
    .instr_i (imemload),
    .pc_i    (pc),
    .npc_i   (pcPlus4),
    .instr_o (skidInstr),
    .pc_o    (skidPc),
    .npc_o   (skidNpc)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next state: flush redirects from anywhere, parking in SQUASH while a miss is outstanding
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ((state_q == FETCH || state_q == SQUASH) && !ihit) ? SQUASH : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (ihit) begin
            if (stall)                                     state_d = HOLD;
            else if (isHalt(imemload[31:26], HALT_OPCODE)) state_d = HALTED;
          end
        end
        HOLD: begin
          if (!stall) state_d = isHalt(skidInstr[31:26], HALT_OPCODE) ? HALTED : FETCH;
        end
        SQUASH: begin
          if (ihit) state_d = FETCH;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs and datapath next values: cache request, PC pacing, skid control and IF/ID update
  always_comb begin
    ifid_d    = ifid_q;
    reqAddr_d = reqAddr_q;
    skidLoad  = 1'b0;
    skidClear = 1'b0;
    pc_incr   = 1'b0;
    imemREN   = 1'b0;
    imemaddr  = pc;

    case (state_q)
      FETCH: begin
        imemREN   = 1'b1;
        reqAddr_d = pc;
        pc_incr   = ihit;
      end
      SQUASH: begin
        imemREN  = 1'b1;
        imemaddr = reqAddr_q;
      end
      default: ;
    endcase

    if (flush) begin
      pc_incr      = 1'b1;
      skidClear    = 1'b1;
      ifid_d.instr = '0;
      ifid_d.valid = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (ihit && !stall) begin
            ifid_d = '{instr: imemload, pc: pc, npc: pcPlus4, valid: 1'b1};
          end else if (ihit) begin
            skidLoad = 1'b1;
          end else if (!stall) begin
            ifid_d.instr = '0;
            ifid_d.valid = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_d    = '{instr: skidInstr, pc: skidPc, npc: skidNpc, valid: 1'b1};
            skidClear = 1'b1;
          end
        end
        HALTED: begin
          if (!stall) begin
            ifid_d.instr = '0;
            ifid_d.valid = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // IF/ID latch and the address of the request in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ifid_q    <= '0;
      reqAddr_q <= '0;
    end else begin
      ifid_q    <= ifid_d;
      reqAddr_q <= reqAddr_d;
    end
  end

  assign ifid_instr = ifid_q.instr;
  assign ifid_pc    = ifid_q.pc;
  assign ifid_npc   = ifid_q.npc;
  assign ifid_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table plus hand-written multi-cycle sequences.
module tb_fetch_unit;

  logic        CLK, RST;
  logic [31:0] pc, imemaddr, imemload, ifid_instr, ifid_pc, ifid_npc;
  logic        pc_incr, imemREN, ihit, stall, flush, ifid_valid;

  int errorCount = 0;
  int checkCount = 0;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        ihit;
    logic [31:0] pc;
    logic [31:0] load;
    logic        expIncr;
    logic        expRen;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInstr;
    logic [31:0] expPc;
    logic [31:0] expNpc;
    logic        chkPc;
  } vec_t;

  vec_t vecs[16];

  fetch_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .pc         (pc),
    .pc_incr    (pc_incr),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .stall      (stall),
    .flush      (flush),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_npc   (ifid_npc),
    .ifid_valid (ifid_valid)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic h,
                               input logic [31:0] p, input logic [31:0] l);
    stall    = s;
    flush    = f;
    ihit     = h;
    pc       = p;
    imemload = l;
    #1;
  endtask

  task automatic checkComb(input string tag, input logic incr, input logic ren, input logic [31:0] addr);
    checkBit($sformatf("%s pc_incr", tag), pc_incr, incr);
    checkBit($sformatf("%s imemREN", tag), imemREN, ren);
    checkOutput($sformatf("%s imemaddr", tag), imemaddr, addr);
  endtask

  task automatic checkIfid(input string tag, input logic v, input logic [31:0] instr,
                           input logic [31:0] ipc, input logic [31:0] inpc, input logic chkPc);
    checkBit($sformatf("%s ifid_valid", tag), ifid_valid, v);
    checkOutput($sformatf("%s ifid_instr", tag), ifid_instr, instr);
    if (chkPc) begin
      checkOutput($sformatf("%s ifid_pc", tag), ifid_pc, ipc);
      checkOutput($sformatf("%s ifid_npc", tag), ifid_npc, inpc);
    end
  endtask

  // One cycle: drive at the falling edge, check comb outputs, then check IF/ID after the rising edge
  task automatic runCycle(input string tag, input logic s, input logic f, input logic h,
                          input logic [31:0] p, input logic [31:0] l,
                          input logic incr, input logic ren, input logic [31:0] addr);
    @(negedge CLK);
    applyStimulus(s, f, h, p, l);
    checkComb(tag, incr, ren, addr);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // stall flush ihit  pc  load | incr ren addr | valid instr pc npc chkPc
    vecs[0]  = '{1'b0,1'b0,1'b1,32'h0,32'h2002000A, 1'b1,1'b1,32'h0, 1'b1,32'h2002000A,32'h0,32'h4,1'b1};
    vecs[1]  = '{1'b0,1'b0,1'b1,32'h4,32'h2002000A, 1'b1,1'b1,32'h4, 1'b1,32'h2002000A,32'h4,32'h8,1'b1};
    vecs[2]  = '{1'b0,1'b0,1'b0,32'h8,32'h0,        1'b0,1'b1,32'h8, 1'b0,32'h0,32'h0,32'h0,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b1,32'h8,32'h8C220004, 1'b1,1'b1,32'h8, 1'b1,32'h8C220004,32'h8,32'hC,1'b1};
    vecs[4]  = '{1'b1,1'b0,1'b1,32'h40,32'hAAAA0001,1'b1,1'b1,32'h40,1'b1,32'h8C220004,32'h8,32'hC,1'b1};
    vecs[5]  = '{1'b1,1'b0,1'b1,32'h44,32'h0,       1'b0,1'b0,32'h44,1'b1,32'h8C220004,32'h8,32'hC,1'b1};
    vecs[6]  = '{1'b1,1'b0,1'b1,32'h44,32'h0,       1'b0,1'b0,32'h44,1'b1,32'h8C220004,32'h8,32'hC,1'b1};
    vecs[7]  = '{1'b0,1'b0,1'b1,32'h44,32'h0,       1'b0,1'b0,32'h44,1'b1,32'hAAAA0001,32'h40,32'h44,1'b1};
    vecs[8]  = '{1'b0,1'b0,1'b1,32'h44,32'h00000020,1'b1,1'b1,32'h44,1'b1,32'h00000020,32'h44,32'h48,1'b1};
    vecs[9]  = '{1'b0,1'b0,1'b1,32'hFFFFFFFC,32'h11111111,1'b1,1'b1,32'hFFFFFFFC,1'b1,32'h11111111,32'hFFFFFFFC,32'h0,1'b1};
    vecs[10] = '{1'b0,1'b1,1'b1,32'h0,32'h22222222, 1'b1,1'b1,32'h0, 1'b0,32'h0,32'h0,32'h0,1'b0};
    vecs[11] = '{1'b1,1'b1,1'b0,32'h100,32'h0,      1'b1,1'b1,32'h100,1'b0,32'h0,32'h0,32'h0,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b1,32'h300,32'h33333333,1'b0,1'b1,32'h100,1'b0,32'h0,32'h0,32'h0,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b1,32'h300,32'h44444444,1'b1,1'b1,32'h300,1'b1,32'h44444444,32'h300,32'h304,1'b1};
    vecs[14] = '{1'b1,1'b0,1'b0,32'h304,32'h0,      1'b0,1'b1,32'h304,1'b1,32'h44444444,32'h300,32'h304,1'b1};
    vecs[15] = '{1'b0,1'b0,1'b0,32'h304,32'h0,      1'b0,1'b1,32'h304,1'b0,32'h0,32'h0,32'h0,1'b0};

    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #11;
    checkIfid("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    checkBit("reset imemREN", imemREN, 1'b1);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 16; i++) begin
      runCycle($sformatf("vec%0d", i), vecs[i].stall, vecs[i].flush, vecs[i].ihit,
               vecs[i].pc, vecs[i].load, vecs[i].expIncr, vecs[i].expRen, vecs[i].expAddr);
      checkIfid($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expInstr,
                vecs[i].expPc, vecs[i].expNpc, vecs[i].chkPc);
    end

    // Miss at 0x80, flush to 0x200 while the miss is outstanding
    runCycle("miss c0", 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 1'b1, 32'h80);
    runCycle("miss c1", 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 1'b1, 32'h80);
    runCycle("miss flush", 1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b1, 32'h80);
    checkIfid("miss flush", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    runCycle("squash c3", 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 1'b1, 32'h80);
    runCycle("squash c4", 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 1'b1, 32'h80);
    runCycle("squash hit", 1'b0, 1'b0, 1'b1, 32'h200, 32'h55555555, 1'b0, 1'b1, 32'h80);
    checkIfid("squash hit", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    runCycle("redirect", 1'b0, 1'b0, 1'b1, 32'h200, 32'h66666666, 1'b1, 1'b1, 32'h200);
    checkIfid("redirect", 1'b1, 32'h66666666, 32'h200, 32'h204, 1'b1);

    // Halt instruction at 0x10 stops fetch until a flush
    runCycle("halt hit", 1'b0, 1'b0, 1'b1, 32'h10, 32'hFC000000, 1'b1, 1'b1, 32'h10);
    checkIfid("halt hit", 1'b1, 32'hFC000000, 32'h10, 32'h14, 1'b1);
    runCycle("halted c1", 1'b0, 1'b0, 1'b1, 32'h14, 32'h0, 1'b0, 1'b0, 32'h14);
    checkIfid("halted c1", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    runCycle("halted c2", 1'b0, 1'b0, 1'b1, 32'h14, 32'h0, 1'b0, 1'b0, 32'h14);
    runCycle("halted flush", 1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, 32'h14);
    runCycle("resume", 1'b0, 1'b0, 1'b1, 32'h20, 32'h77777777, 1'b1, 1'b1, 32'h20);
    checkIfid("resume", 1'b1, 32'h77777777, 32'h20, 32'h24, 1'b1);

    // Reset while HOLD has a word parked in the skid buffer
    runCycle("hold entry", 1'b1, 1'b0, 1'b1, 32'h60, 32'h88888888, 1'b1, 1'b1, 32'h60);
    checkBit("hold imemREN", imemREN, 1'b0);
    checkIfid("hold entry", 1'b1, 32'h77777777, 32'h20, 32'h24, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    checkIfid("async reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    @(negedge CLK);
    RST = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h64, 32'h0);
    checkComb("post reset", 1'b0, 1'b1, 32'h64);
    @(posedge CLK);
    #1;
    checkIfid("post reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
